// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, programmable stability
// counter, registered debounced level with one-cycle rise/fall pulses.
module debouncer_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   CNT_WIDTH   = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] debounce_cycles_i,
  input  logic [CHANNELS-1:0]  sw_i,
  output logic [CHANNELS-1:0]  sw_o,
  output logic [CHANNELS-1:0]  rise_o,
  output logic [CHANNELS-1:0]  fall_o
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [CNT_WIDTH:0]                   neff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {(SYNC_STAGES*CHANNELS){RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A programmed threshold of zero behaves as one; the extra bit keeps cnt+1 from wrapping.
  assign neff = (debounce_cycles_i == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, debounce_cycles_i};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 lvl;
    logic                 rise;
    logic                 fall;

    assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt  <= '0;
        lvl  <= RESET_LEVEL;
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (!enable_i || (s[c] == lvl)) begin
          cnt <= '0;
        end else if (cnt_inc >= neff) begin
          // >= lets a lowered threshold take effect immediately instead of wrapping
          lvl  <= s[c];
          cnt  <= '0;
          rise <= s[c];
          fall <= ~s[c];
        end else begin
          cnt <= cnt_inc[CNT_WIDTH-1:0];
        end
      end
    end

    assign sw_o[c]   = lvl;
    assign rise_o[c] = rise;
    assign fall_o[c] = fall;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: stimulus pushes expected output events with
// their edge number; a monitor pops one entry whenever sw_o changes or a pulse appears.
module tb_debouncer_multi;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [CW-1:0] ncyc = 16'd120;
  logic [CH-1:0] sw_in = '0;
  logic [CH-1:0] sw_out, rise, fall;

  typedef struct packed {
    int unsigned cyc;
    logic [CH-1:0] sw;
    logic [CH-1:0] rs;
    logic [CH-1:0] fl;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [CH-1:0] prev_sw = '0;

  debouncer_multi #(
    .CHANNELS(CH), .CNT_WIDTH(CW), .SYNC_STAGES(SS), .RESET_LEVEL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .debounce_cycles_i(ncyc),
    .sw_i(sw_in), .sw_o(sw_out), .rise_o(rise), .fall_o(fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every visible output event must match the head of the queue exactly.
  always @(negedge clk) begin
    ev_t got, e;
    if ((rise != '0) || (fall != '0) || (sw_out != prev_sw)) begin
      got = '{cyc: cyc, sw: sw_out, rs: rise, fl: fall};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got sw=%b rise=%b fall=%b, required no event",
                 cyc, sw_out, rise, fall);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          miscompares++;
          $display("FAIL event got cyc=%0d sw=%b rise=%b fall=%b, required cyc=%0d sw=%b rise=%b fall=%b",
                   got.cyc, got.sw, got.rs, got.fl, e.cyc, e.sw, e.rs, e.fl);
        end
      end
    end
    prev_sw = sw_out;
  end

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got %b, required %b", name, act, req);
    end
  endtask

  // Called at a negedge right after changing sw_i: the next edge samples it.
  task automatic expect_at(input int unsigned dly, input logic [CH-1:0] sw,
                           input logic [CH-1:0] rs, input logic [CH-1:0] fl);
    exp_q.push_back('{cyc: cyc + dly, sw: sw, rs: rs, fl: fl});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int len;
    // Reset with toggling inputs: outputs stay low throughout.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sw_in = ~sw_in;
      check("reset_sw", sw_out, 4'b0000);
      check("reset_pulse", rise | fall, 4'b0000);
      @(negedge clk);
    end
    sw_in = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(5);
    check("post_reset_sw", sw_out, 4'b0000);

    // Clean press and release on channel 0, N=120.
    sw_in[0] = 1'b1; expect_at(SS + 120, 4'b0001, 4'b0001, 4'b0000);
    wait_cycles(240);
    check("press_level", sw_out, 4'b0001);
    sw_in[0] = 1'b0; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b0001);
    wait_cycles(240);

    // Bounce on channel 1: every run is shorter than N, so nothing may happen.
    for (int i = 0; i < 50; i++) begin
      sw_in[1] = 1'b1; len = $urandom_range(119, 60); wait_cycles(len);
      sw_in[1] = 1'b0; len = $urandom_range(119, 60); wait_cycles(len);
    end
    check("bounce_level", sw_out, 4'b0000);
    sw_in[1] = 1'b1; expect_at(SS + 120, 4'b0010, 4'b0010, 4'b0000);
    wait_cycles(200);
    sw_in[1] = 1'b0; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b0010);
    wait_cycles(130);

    // Two channels change on the same edge.
    sw_in = 4'b1010; expect_at(SS + 120, 4'b1010, 4'b1010, 4'b0000);
    wait_cycles(130);
    sw_in = 4'b0000; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b1010);
    wait_cycles(130);

    // Disabled during a press: frozen, then a full N after re-enable.
    en = 1'b0;
    sw_in[2] = 1'b1;
    wait_cycles(150);
    check("disabled_frozen", sw_out, 4'b0000);
    en = 1'b1; expect_at(120, 4'b0100, 4'b0100, 4'b0000);
    wait_cycles(130);
    sw_in[2] = 1'b0; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b0100);
    wait_cycles(130);

    // N=0 behaves as N=1.
    ncyc = '0;
    wait_cycles(2);
    sw_in[3] = 1'b1; expect_at(SS + 1, 4'b1000, 4'b1000, 4'b0000);
    wait_cycles(10);
    sw_in[3] = 1'b0; expect_at(SS + 1, 4'b0000, 4'b0000, 4'b1000);
    wait_cycles(10);
    ncyc = 16'd120;
    wait_cycles(2);

    // Lower N from 120 to 10 once the count has reached 50: flips on the next edge.
    sw_in[0] = 1'b1;
    wait_cycles(SS + 50);
    ncyc = 16'd10; expect_at(1, 4'b0001, 4'b0001, 4'b0000);
    wait_cycles(20);
    ncyc = 16'd120;
    sw_in[0] = 1'b0; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b0001);
    wait_cycles(130);

    // Reset at count 100 of 120: partial count discarded, full N after release.
    sw_in[1] = 1'b1;
    wait_cycles(SS + 100);
    rst = 1'b1;
    wait_cycles(2);
    check("midreset_sw", sw_out, 4'b0000);
    check("midreset_pulse", rise | fall, 4'b0000);
    rst = 1'b0; expect_at(SS + 120, 4'b0010, 4'b0010, 4'b0000);
    wait_cycles(130);
    sw_in[1] = 1'b0; expect_at(SS + 120, 4'b0000, 4'b0000, 4'b0010);
    wait_cycles(130);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Parametrised multi-channel switch/button debouncer, next generation of the single-channel debouncer IP. Each channel synchronises an asynchronous input, requires it to hold a new level for a runtime-programmable number of consecutive clock cycles, then updates its debounced output and emits one-cycle rise/fall pulses. It sits between board-level switch/button pins and control logic, one instance per input bank.

Parameters:
CHANNELS, 4, number of independent input channels (1..32)
CNT_WIDTH, 16, width of the stability counter and of debounce_cycles_i
SYNC_STAGES, 2, synchroniser flip-flops per channel (2..4)
RESET_LEVEL, 1'b0, reset value of the synchroniser flops and sw_o for every channel

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
enable_i  input  1  1 = debouncing active; 0 = freeze outputs and clear counters
debounce_cycles_i  input  CNT_WIDTH  required stable cycles N (quasi-static, shared by all channels)
sw_i  input  CHANNELS  raw asynchronous switch inputs
sw_o  output  CHANNELS  debounced levels
rise_o  output  CHANNELS  one-cycle pulse when sw_o[c] goes 0->1
fall_o  output  CHANNELS  one-cycle pulse when sw_o[c] goes 1->0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset (async assert, sync-to-clk release by integration): sync flops = RESET_LEVEL, sw_o = {CHANNELS{RESET_LEVEL}}, counters = 0, rise_o = fall_o = 0. Reset mid-debounce discards the partial count; no pulses during or on exit from reset.
- Per channel c, independently: s[c] = output of SYNC_STAGES-deep synchroniser on sw_i[c].
- Effective threshold Neff = (debounce_cycles_i == 0) ? 1 : debounce_cycles_i.
- Each cycle with enable_i = 1:
  - s[c] == sw_o[c]: cnt[c] <= 0.
  - s[c] != sw_o[c] and cnt[c] + 1 >= Neff: sw_o[c] <= s[c], cnt[c] <= 0, rise_o[c]/fall_o[c] <= 1 per direction for exactly that cycle.
  - otherwise cnt[c] <= cnt[c] + 1.
- Comparison uses >= so lowering debounce_cycles_i mid-count flips on the next cycle instead of wrapping; counter never exceeds Neff-1, no overflow possible.
- Pulses registered, coincident with sw_o change (same cycle sw_o shows new value); rise_o and fall_o never both high on one channel.
- Latency: if sw_i[c] changes before edge k and stays stable, sw_o[c] changes on edge k + SYNC_STAGES - 1 + Neff. Any glitch returning s[c] to sw_o[c] before that restarts the count from 0.
- enable_i = 0: synchronisers keep running, cnt = 0, sw_o held, rise_o/fall_o = 0. Re-enable: counting starts fresh at the next cycle; a level differing from sw_o needs a full Neff stable cycles.
- Simultaneous events on different channels are fully independent; multiple rise/fall bits may assert in one cycle.
- debounce_cycles_i must change only with enable_i = 0 or tolerate the >= rule above; no other side effects.

Test Plan:
- Reset: rst_i=1 for 2 cycles with sw_i toggling -> sw_o=0, rise_o=fall_o=0 throughout; counters 0 after release.
- Clean press, N=120, SYNC_STAGES=2: sw_i[0] 0->1 held 240 cycles -> sw_o[0]=1 exactly 121 edges after first sampling edge, rise_o[0] high 1 cycle; release -> fall_o[0] pulse after same 121 edges.
- Bounce: 50 iterations sw_i[1] high/low each for random 60..119 cycles, N=120 -> sw_o[1] never changes, no pulses; final hold 200 cycles high -> one rise_o[1].
- Multi-channel: sw_i=4'b1010 at same edge -> sw_o=4'b1010 same cycle, rise_o=4'b1010 single cycle, other channels silent.
- Enable/threshold: enable_i=0 during 150-cycle press -> sw_o frozen; re-enable -> change after full 120 cycles; N=0 -> change 2 cycles after input (treated as 1); lowering N 120->10 at count 50 -> flip next cycle.
- Reset mid-operation: rst_i pulse at count 100 of 120 -> sw_o stays RESET_LEVEL, no pulse, count restarts from 0 after release.
